// File: rtl/pong_pkg.sv
// Shared types, constants and helpers for the Pong ball datapath.
package pong_pkg;

    // Ball engine states; the encoding is visible on the state output.
    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_SERVE_WAIT = 2'd1,
        ST_PLAY       = 2'd2,
        ST_SCORED     = 2'd3
    } ball_state_t;

    // Galois tap mask for x^8 + x^6 + x^5 + x^4 + 1 with a right-shifting register.
    localparam int          LFSR_W    = 8;
    localparam logic [7:0]  LFSR_TAPS = 8'hB8;

    // Fixed-point coordinate of the centre of a dimension of 'dim' pixels.
    function automatic int centre_fx(input int dim, input int frac_w);
        return (dim / 2) << frac_w;
    endfunction

    // Fixed-point coordinate of the last pixel of a dimension of 'dim' pixels.
    function automatic int edge_fx(input int dim, input int frac_w);
        return (dim - 1) << frac_w;
    endfunction

    // Speed increase that never passes the ceiling.
    function automatic int sat_add(input int a, input int b, input int limit);
        return (a + b > limit) ? limit : a + b;
    endfunction

endpackage

// File: rtl/serve_lfsr.sv
// 8-bit Galois LFSR supplying the random serve direction and slope bits.
module serve_lfsr
    import pong_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_en,
    output logic [3:0] o_draw
);

    logic [LFSR_W-1:0] r_lfsr;

    // Shift right each enabled cycle, folding the dropped bit back in through the taps.
    // NOTE: clocked state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lfsr <= SEED;
        end else if (i_en) begin
            r_lfsr <= {1'b0, r_lfsr[LFSR_W-1:1]} ^ (r_lfsr[0] ? LFSR_TAPS : '0);
        end
    end

    assign o_draw = r_lfsr[3:0];

endmodule

// File: rtl/ball_motion_ctrl.sv
// Fixed-point ball engine: serve, wall and paddle bounces, speed-up and scoring.
module ball_motion_ctrl
    import pong_pkg::*;
#(
    parameter int          FIELD_W     = 64,
    parameter int          FIELD_H     = 64,
    parameter int          FRAC_W      = 4,
    parameter int          VEL_INIT    = 8,
    parameter int          VEL_STEP    = 4,
    parameter int          VEL_MAX     = 32,
    parameter int          SERVE_DELAY = 4,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5,
    localparam int         PX_W        = $clog2(FIELD_W),
    localparam int         PY_W        = $clog2(FIELD_H),
    localparam int         VEL_W       = $clog2(VEL_MAX + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             move_tick,
    input  logic             serve,
    input  logic             paddle_hit_l,
    input  logic             paddle_hit_r,
    output logic [PX_W-1:0]  ball_x,
    output logic [PY_W-1:0]  ball_y,
    output logic             dir_x,
    output logic             dir_y,
    output logic [VEL_W-1:0] speed,
    output logic [1:0]       state,
    output logic             point_l,
    output logic             point_r
);

    // Position registers carry FRAC_W fraction bits; arithmetic gets one guard bit.
    localparam int X_W   = PX_W + FRAC_W;
    localparam int Y_W   = PY_W + FRAC_W;
    localparam int AX_W  = X_W + 1;
    localparam int AY_W  = Y_W + 1;
    localparam int CNT_W = $clog2(SERVE_DELAY + 1);

    localparam logic [X_W-1:0]  CENTER_X = X_W'(centre_fx(FIELD_W, FRAC_W));
    localparam logic [Y_W-1:0]  CENTER_Y = Y_W'(centre_fx(FIELD_H, FRAC_W));
    localparam logic [AX_W-1:0] X_EDGE   = AX_W'(edge_fx(FIELD_W, FRAC_W));
    localparam logic [AY_W-1:0] Y_EDGE   = AY_W'(edge_fx(FIELD_H, FRAC_W));

    ball_state_t      r_state;
    logic [X_W-1:0]   r_x;
    logic [Y_W-1:0]   r_y;
    logic             r_dir_x;
    logic             r_dir_y;
    logic [VEL_W-1:0] r_speed;
    logic [VEL_W-1:0] r_vy_mag;
    logic [CNT_W-1:0] r_cnt;
    logic             r_point_l;
    logic             r_point_r;
    logic             r_pend_l;
    logic             r_pend_r;

    logic [3:0]       w_draw;
    logic [VEL_W-1:0] w_draw_vy;
    logic [VEL_W-1:0] w_speed_up;
    logic [AX_W-1:0]  w_x_ext;
    logic [AX_W-1:0]  w_spd_ext;
    logic [AX_W-1:0]  w_x_plus;
    logic [AY_W-1:0]  w_y_ext;
    logic [AY_W-1:0]  w_vy_ext;
    logic [AY_W-1:0]  w_y_plus;
    logic             w_bounce;
    logic             w_exit_left;
    logic             w_exit_right;
    logic [X_W-1:0]   w_x_next;
    logic [Y_W-1:0]   w_y_next;
    logic             w_flip_y;

    serve_lfsr #(
        .SEED   (LFSR_SEED)
    ) u_lfsr (
        .clk    (clk),
        .reset  (reset),
        .i_en   (1'b1),
        .o_draw (w_draw)
    );

    assign w_draw_vy  = VEL_W'(VEL_INIT >> w_draw[3:2]);
    assign w_speed_up = VEL_W'(sat_add(int'(r_speed), VEL_STEP, VEL_MAX));
    assign w_x_ext    = {1'b0, r_x};
    assign w_spd_ext  = AX_W'(r_speed);
    assign w_x_plus   = w_x_ext + w_spd_ext;
    assign w_y_ext    = {1'b0, r_y};
    assign w_vy_ext   = AY_W'(r_vy_mag);
    assign w_y_plus   = w_y_ext + w_vy_ext;

    // A bounce is due when a hit toward the current direction is pending or arriving now.
    assign w_bounce = r_dir_x ? (r_pend_r | paddle_hit_r) : (r_pend_l | paddle_hit_l);

    // Next X on a move tick: bounce moves the old speed the new way, else move or exit.
    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        w_x_next     = r_x;
        w_exit_left  = 1'b0;
        w_exit_right = 1'b0;
        if (w_bounce) begin
            if (r_dir_x) begin
                w_x_next = (w_x_ext < w_spd_ext) ? '0 : X_W'(w_x_ext - w_spd_ext);
            end else begin
                w_x_next = (w_x_plus > X_EDGE) ? X_EDGE[X_W-1:0] : X_W'(w_x_plus);
            end
        end else if (!r_dir_x) begin
            if (w_x_ext < w_spd_ext) begin
                w_x_next    = '0;
                w_exit_left = 1'b1;
            end else begin
                w_x_next = X_W'(w_x_ext - w_spd_ext);
            end
        end else begin
            if (w_x_plus > X_EDGE) begin
                w_x_next     = X_EDGE[X_W-1:0];
                w_exit_right = 1'b1;
            end else begin
                w_x_next = X_W'(w_x_plus);
            end
        end
    end

    // Next Y on a move tick: clamp onto a wall and flip, otherwise move by vy_mag.
    always_comb begin
        w_y_next = r_y;
        w_flip_y = 1'b0;
        if (r_dir_y) begin
            if (w_y_plus >= Y_EDGE) begin
                w_y_next = Y_EDGE[Y_W-1:0];
                w_flip_y = 1'b1;
            end else begin
                w_y_next = Y_W'(w_y_plus);
            end
        end else begin
            if (w_y_ext <= w_vy_ext) begin
                w_y_next = '0;
                w_flip_y = 1'b1;
            end else begin
                w_y_next = Y_W'(w_y_ext - w_vy_ext);
            end
        end
    end

    // Rally state machine; owns position, direction, speeds, hit latches and score pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_x       <= CENTER_X;
            r_y       <= CENTER_Y;
            r_dir_x   <= 1'b1;
            r_dir_y   <= 1'b1;
            r_speed   <= VEL_W'(VEL_INIT);
            r_vy_mag  <= VEL_W'(VEL_INIT);
            r_cnt     <= '0;
            r_point_l <= 1'b0;
            r_point_r <= 1'b0;
            r_pend_l  <= 1'b0;
            r_pend_r  <= 1'b0;
        end else begin
            r_point_l <= 1'b0;
            r_point_r <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (serve) begin
                        r_dir_x  <= w_draw[0];
                        r_dir_y  <= w_draw[1];
                        r_vy_mag <= w_draw_vy;
                        r_speed  <= VEL_W'(VEL_INIT);
                        r_cnt    <= CNT_W'(SERVE_DELAY);
                        r_state  <= ST_SERVE_WAIT;
                    end
                end
                ST_SERVE_WAIT: begin
                    if (move_tick) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                        if (r_cnt <= CNT_W'(1)) begin
                            r_state <= ST_PLAY;
                        end
                    end
                end
                ST_PLAY: begin
                    if (!move_tick) begin
                        if (paddle_hit_l && !r_dir_x) r_pend_l <= 1'b1;
                        if (paddle_hit_r &&  r_dir_x) r_pend_r <= 1'b1;
                    end else begin
                        r_x <= w_x_next;
                        r_y <= w_y_next;
                        if (w_flip_y) r_dir_y <= ~r_dir_y;
                        if (w_bounce) begin
                            r_dir_x  <= ~r_dir_x;
                            r_speed  <= w_speed_up;
                            r_pend_l <= 1'b0;
                            r_pend_r <= 1'b0;
                        end else if (w_exit_left) begin
                            r_point_r <= 1'b1;
                            r_state   <= ST_SCORED;
                        end else if (w_exit_right) begin
                            r_point_l <= 1'b1;
                            r_state   <= ST_SCORED;
                        end
                    end
                end
                ST_SCORED: begin
                    if (move_tick) begin
                        r_x      <= CENTER_X;
                        r_y      <= CENTER_Y;
                        r_dir_x  <= w_draw[0];
                        r_dir_y  <= w_draw[1];
                        r_vy_mag <= w_draw_vy;
                        r_speed  <= VEL_W'(VEL_INIT);
                        r_cnt    <= CNT_W'(SERVE_DELAY);
                        r_state  <= ST_SERVE_WAIT;
                    end
                end
            endcase
        end
    end

    assign ball_x  = r_x[X_W-1:FRAC_W];
    assign ball_y  = r_y[Y_W-1:FRAC_W];
    assign dir_x   = r_dir_x;
    assign dir_y   = r_dir_y;
    assign speed   = r_speed;
    assign state   = r_state;
    assign point_l = r_point_l;
    assign point_r = r_point_r;

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Self-checking bench for ball_motion_ctrl: vector table, directed corners, random vs model.
module tb_ball_motion_ctrl;

    localparam int FIELD_W  = 64;
    localparam int FIELD_H  = 64;
    localparam int FRAC_W   = 4;
    localparam int VEL_INIT = 8;
    localparam int VEL_STEP = 4;
    localparam int VEL_MAX  = 32;
    localparam int DELAY    = 4;
    localparam int ONE      = 1 << FRAC_W;
    localparam int XE       = (FIELD_W - 1) * ONE;
    localparam int YE       = (FIELD_H - 1) * ONE;
    localparam int CX       = (FIELD_W / 2) * ONE;
    localparam int CY       = (FIELD_H / 2) * ONE;

    logic       clk = 1'b0;
    logic       reset, move_tick, serve, paddle_hit_l, paddle_hit_r;
    logic [5:0] ball_x, ball_y, speed;
    logic       dir_x, dir_y, point_l, point_r;
    logic [1:0] state;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ball_motion_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .move_tick    (move_tick),
        .serve        (serve),
        .paddle_hit_l (paddle_hit_l),
        .paddle_hit_r (paddle_hit_r),
        .ball_x       (ball_x),
        .ball_y       (ball_y),
        .dir_x        (dir_x),
        .dir_y        (dir_y),
        .speed        (speed),
        .state        (state),
        .point_l      (point_l),
        .point_r      (point_r)
    );

    // Reference model: signed integer positions in 1/ONE px, states as plain numbers.
    int       m_state, m_x, m_y, m_dx, m_dy, m_spd, m_vy, m_cnt, m_pl, m_pr, m_pend_l, m_pend_r;
    bit [7:0] m_lfsr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_launch(input bit [7:0] bits);
        m_dx  = bits[0];
        m_dy  = bits[1];
        m_vy  = VEL_INIT / (1 << bits[3:2]);
        m_spd = VEL_INIT;
        m_cnt = DELAY;
    endtask

    task automatic model_play_tick(input bit hl, input bit hr);
        int  step;
        int  ystep;
        bit  bounce;
        step   = m_dx ? m_spd : -m_spd;
        bounce = m_dx ? (m_pend_r != 0 || hr) : (m_pend_l != 0 || hl);
        if (bounce) begin
            m_x = m_x - step;
            if (m_x < 0)  m_x = 0;
            if (m_x > XE) m_x = XE;
            m_dx  = 1 - m_dx;
            m_spd = (m_spd + VEL_STEP > VEL_MAX) ? VEL_MAX : m_spd + VEL_STEP;
            m_pend_l = 0;
            m_pend_r = 0;
        end else if (m_x + step < 0) begin
            m_x = 0;  m_pr = 1; m_state = 3;
        end else if (m_x + step > XE) begin
            m_x = XE; m_pl = 1; m_state = 3;
        end else begin
            m_x = m_x + step;
        end
        ystep = m_dy ? m_vy : -m_vy;
        if (m_dy != 0 && m_y + ystep >= YE) begin
            m_y = YE; m_dy = 0;
        end else if (m_dy == 0 && m_y + ystep <= 0) begin
            m_y = 0;  m_dy = 1;
        end else begin
            m_y = m_y + ystep;
        end
    endtask

    task automatic model_step(input bit rst, input bit tick, input bit srv, input bit hl, input bit hr);
        bit [7:0] cur;
        cur = m_lfsr;
        if (rst) begin
            m_state = 0; m_x = CX; m_y = CY; m_dx = 1; m_dy = 1;
            m_spd = VEL_INIT; m_vy = VEL_INIT; m_cnt = 0;
            m_pl = 0; m_pr = 0; m_pend_l = 0; m_pend_r = 0;
            m_lfsr = 8'hA5;
            return;
        end
        m_lfsr = {1'b0, cur[7:1]} ^ (cur[0] ? 8'hB8 : 8'h00);
        m_pl = 0;
        m_pr = 0;
        case (m_state)
            0: if (srv) begin model_launch(cur); m_state = 1; end
            1: if (tick) begin m_cnt--; if (m_cnt == 0) m_state = 2; end
            2: begin
                if (!tick) begin
                    if (hl && m_dx == 0) m_pend_l = 1;
                    if (hr && m_dx == 1) m_pend_r = 1;
                end else begin
                    model_play_tick(hl, hr);
                end
            end
            default: if (tick) begin m_x = CX; m_y = CY; model_launch(cur); m_state = 1; end
        endcase
    endtask

    // One clock: drive at the falling edge, update model at the rising edge, return at the next fall.
    task automatic apply(input bit rst, input bit tick, input bit srv, input bit hl, input bit hr);
        reset = rst; move_tick = tick; serve = srv; paddle_hit_l = hl; paddle_hit_r = hr;
        @(posedge clk);
        model_step(rst, tick, srv, hl, hr);
        @(negedge clk);
    endtask

    task automatic compare_model(input string tag);
        check({tag, ".state"},   state,   m_state);
        check({tag, ".ball_x"},  ball_x,  m_x / ONE);
        check({tag, ".ball_y"},  ball_y,  m_y / ONE);
        check({tag, ".dir_x"},   dir_x,   m_dx);
        check({tag, ".dir_y"},   dir_y,   m_dy);
        check({tag, ".speed"},   speed,   m_spd);
        check({tag, ".point_l"}, point_l, m_pl);
        check({tag, ".point_r"}, point_r, m_pr);
    endtask

    function automatic bit would_exit();
        return (m_dx != 0 && m_x + m_spd > XE) || (m_dx == 0 && m_x < m_spd);
    endfunction

    typedef struct {
        bit rst, tick, srv, hl, hr;
        int st, x, y, dx, dy, spd;
    } vec_t;

    vec_t tbl[16];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Hand-derived from seed 8'hA5: dir_x=1, dir_y=0, vy_mag=4 on the first serve.
        tbl[0]  = '{1,0,0,0,0, 0,32,32,1,1, 8};
        tbl[1]  = '{0,0,1,0,0, 1,32,32,1,0, 8};
        tbl[2]  = '{0,1,0,0,0, 1,32,32,1,0, 8};
        tbl[3]  = '{0,1,0,0,0, 1,32,32,1,0, 8};
        tbl[4]  = '{0,1,0,0,0, 1,32,32,1,0, 8};
        tbl[5]  = '{0,1,0,0,0, 2,32,32,1,0, 8};
        tbl[6]  = '{0,1,0,0,0, 2,32,31,1,0, 8};
        tbl[7]  = '{0,1,0,0,0, 2,33,31,1,0, 8};
        tbl[8]  = '{0,0,1,0,0, 2,33,31,1,0, 8};
        tbl[9]  = '{0,0,0,0,1, 2,33,31,1,0, 8};
        tbl[10] = '{0,1,0,0,0, 2,32,31,0,0,12};
        tbl[11] = '{0,0,0,0,1, 2,32,31,0,0,12};
        tbl[12] = '{0,1,0,0,0, 2,31,31,0,0,12};
        tbl[13] = '{0,0,0,1,0, 2,31,31,0,0,12};
        tbl[14] = '{0,1,0,0,0, 2,32,30,1,0,16};
        tbl[15] = '{1,0,0,0,0, 0,32,32,1,1, 8};

        reset = 1'b1; move_tick = 1'b0; serve = 1'b0; paddle_hit_l = 1'b0; paddle_hit_r = 1'b0;
        @(negedge clk);
        apply(1, 0, 0, 0, 0);
        apply(1, 0, 0, 0, 0);

        for (int i = 0; i < 16; i++) begin
            apply(tbl[i].rst, tbl[i].tick, tbl[i].srv, tbl[i].hl, tbl[i].hr);
            check($sformatf("vec%0d.state", i),   state,   tbl[i].st);
            check($sformatf("vec%0d.ball_x", i),  ball_x,  tbl[i].x);
            check($sformatf("vec%0d.ball_y", i),  ball_y,  tbl[i].y);
            check($sformatf("vec%0d.dir_x", i),   dir_x,   tbl[i].dx);
            check($sformatf("vec%0d.dir_y", i),   dir_y,   tbl[i].dy);
            check($sformatf("vec%0d.speed", i),   speed,   tbl[i].spd);
            check($sformatf("vec%0d.points", i),  {point_l, point_r}, 0);
        end

        // Speed-up saturates after six returns, and a seventh keeps it at the ceiling.
        apply(0, 0, 1, 0, 0);
        for (int i = 0; i < DELAY; i++) begin apply(0, 1, 0, 0, 0); compare_model("serve"); end
        check("serve.in_play", state, 2);
        for (int i = 0; i < 7; i++) begin
            apply(0, 1, 0, m_dx == 0, m_dx == 1);
            compare_model("ret");
            if (i == 5) check("speed_sat6", speed, VEL_MAX);
        end
        check("speed_sat7", speed, VEL_MAX);

        // Let the ball leave the field; the point pulse lasts exactly one cycle.
        begin
            int budget = 4000;
            while (m_state == 2 && budget > 0) begin
                apply(0, 1, 0, 0, 0);
                compare_model("exit");
                budget--;
            end
            check("exit.reached", budget > 0, 1);
            check("exit.state", state, 3);
            check("exit.pulse", point_l ^ point_r, 1);
            apply(0, 0, 0, 0, 0);
            compare_model("scored_hold");
            check("exit.pulse_width", {point_l, point_r}, 0);
            check("exit.still_scored", state, 3);
            apply(0, 1, 0, 0, 0);
            compare_model("recentre");
            check("recentre.state", state, 1);
            check("recentre.x", ball_x, 32);
            check("recentre.y", ball_y, 32);
            check("recentre.speed", speed, VEL_INIT);
        end

        // A paddle hit on the tick that would otherwise exit wins: bounce, no point.
        begin
            int budget = 3000;
            int old_dx;
            bit done = 0;
            while (!done && budget > 0) begin
                if (m_state == 2 && would_exit()) begin
                    old_dx = m_dx;
                    apply(0, 1, 0, m_dx == 0, m_dx == 1);
                    compare_model("hit_exit");
                    check("hit_exit.state", state, 2);
                    check("hit_exit.points", {point_l, point_r}, 0);
                    check("hit_exit.dir_x", dir_x, 1 - old_dx);
                    done = 1;
                end else begin
                    apply(0, 1, 0, 0, 0);
                    compare_model("approach");
                end
                budget--;
            end
            check("hit_exit.reached", done, 1);
        end

        // Reset in the middle of a rally restores every reset value.
        apply(0, 1, 1, 0, 0);
        check("mid.in_play", state, 2);
        apply(1, 1, 0, 0, 0);
        check("rst.state", state, 0);
        check("rst.x", ball_x, 32);
        check("rst.y", ball_y, 32);
        check("rst.dir", {dir_x, dir_y}, 3);
        check("rst.speed", speed, VEL_INIT);
        check("rst.points", {point_l, point_r}, 0);

        // Random play against the model; paddles only report hits near their own edge.
        for (int i = 0; i < 8000; i++) begin
            bit t  = ($urandom_range(0, 2) == 0);
            bit s  = ($urandom_range(0, 7) == 0);
            bit hl = (m_x < 6 * ONE)  && ($urandom_range(0, 3) == 0);
            bit hr = (m_x > 57 * ONE) && ($urandom_range(0, 3) == 0);
            bit r  = ($urandom_range(0, 2999) == 0);
            apply(r, t, s, hl, hr);
            compare_model("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ball_motion_ctrl.md
Name: ball_motion_ctrl

Overview:
Parametrised ball engine for the Pong datapath. Holds the ball position in fixed point and moves it once per move_tick using a speed register. It bounces off the top and bottom walls itself, and bounces off paddles using hit flags from the collision detector. It serves with an LFSR-randomised direction and slope, speeds the ball up on every paddle return, and emits a one-cycle scoring pulse when the ball leaves the field.

Parameters:
FIELD_W, 64, playfield width in pixels (power of two); PX_W = clog2(FIELD_W)
FIELD_H, 64, playfield height in pixels (power of two); PY_W = clog2(FIELD_H)
FRAC_W, 4, fractional bits of position and velocity
VEL_INIT, 8, serve speed in 1/2^FRAC_W px per tick; must be >= 8
VEL_STEP, 4, speed added per paddle return
VEL_MAX, 32, speed ceiling; VEL_W = clog2(VEL_MAX+1)
SERVE_DELAY, 4, move_ticks the ball rests at centre before launch
LFSR_SEED, 8'hA5, LFSR reset value; must be non-zero

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
move_tick  in  1  one-cycle movement strobe (frame rate)
serve  in  1  start-rally request; honoured only in IDLE
paddle_hit_l  in  1  ball overlaps left paddle (any cycle)
paddle_hit_r  in  1  ball overlaps right paddle (any cycle)
ball_x  out  PX_W  integer part of X position
ball_y  out  PY_W  integer part of Y position
dir_x  out  1  1 = moving right
dir_y  out  1  1 = moving down
speed  out  VEL_W  current X speed
state  out  2  0 IDLE, 1 SERVE_WAIT, 2 PLAY, 3 SCORED
point_l  out  1  one-cycle pulse: left player scores (ball exited right)
point_r  out  1  one-cycle pulse: right player scores (ball exited left)

Behaviour:
- All outputs are registered. Reset is synchronous, active-high; clock is clk. Reset values: position (FIELD_W/2, FIELD_H/2) with zero fraction, dir_x=1, dir_y=1, speed=VEL_INIT, vy_mag=VEL_INIT, state IDLE, point_l/point_r 0, LFSR=LFSR_SEED, pending hit flags 0.
- LFSR: 8-bit Galois, polynomial x^8+x^6+x^5+x^4+1. Steps every clk in every state and never reaches zero.
- Launch draw: dir_x=lfsr[0], dir_y=lfsr[1], vy_mag=VEL_INIT>>lfsr[3:2] (never zero), speed=VEL_INIT, delay counter=SERVE_DELAY.
- IDLE: ball held at centre. If serve=1, take the launch draw and go to SERVE_WAIT.
- SERVE_WAIT: ball held at centre. Each move_tick decrements the counter. The tick that brings the counter to 0 moves to PLAY; the ball does not move on that tick.
- PLAY, outside move_tick: paddle_hit_l sets pend_l only when dir_x=0; paddle_hit_r sets pend_r only when dir_x=1. Hits toward the away direction are ignored, which prevents a double bounce.
- PLAY, move_tick, X axis:
  - If the pending flag for the current direction is set (or the matching hit input is high this cycle), flip dir_x, set speed=min(speed+VEL_STEP, VEL_MAX), and clear both flags. X still moves by the old speed in the new direction.
  - Otherwise, when moving left with x < speed, or moving right with x+speed > (FIELD_W-1)<<FRAC_W: clamp x to the edge, pulse point_r or point_l respectively, and go to SCORED.
  - Otherwise x += or -= speed.
- PLAY, move_tick, Y axis:
  - Moving down with y+vy_mag >= (FIELD_H-1)<<FRAC_W: clamp y to that value and flip dir_y.
  - Moving up with y <= vy_mag: clamp y to 0 and flip dir_y.
  - Otherwise y moves by vy_mag.
- Same-tick events: a paddle bounce beats an exit. A wall flip and a paddle flip in the same tick both apply (corner). Arithmetic is computed at PX_W+FRAC_W+1 bits; no wrap-around is permitted.
- SCORED: ball held at the edge. The next move_tick recentres the ball, takes a fresh launch draw, and goes to SERVE_WAIT.
- serve outside IDLE is ignored. Reset mid-rally returns all reset values on the following cycle.
- Latency: position changes are visible the cycle after the move_tick edge. point_* is high for exactly that one cycle.

Decomposition:
- Package pong_pkg: state enum; LFSR tap constant; CENTER_X/CENTER_Y and fixed-point edge constants derived from parameters; a saturating-add function for speed.
- Sub-module serve_lfsr: 8-bit Galois LFSR with seed parameter and enable input.

Test Plan:
- Reset (defaults) -> ball (32,32), state 0, speed 8, point_l=point_r=0, dir_x=1, dir_y=1.
- serve=1 in IDLE, then 4 move_ticks -> state 2, ball stays (32,32). After 2 further ticks ball_x is 33 if dir_x=1, or 31 if dir_x=0 (0.5 px/tick).
- Ball moving down with y internal 1000, vy_mag 8, on move_tick -> y clamps to 1008 (ball_y 63), dir_y=0. Next tick ball_y decreases.
- paddle_hit_l pulsed mid-frame with dir_x=0 -> next move_tick dir_x=1, speed 12. Six alternating returns -> speed saturates at 32. paddle_hit_r asserted while dir_x=0 -> no effect.
- Ball moving right at x=1000, speed 16, no hit -> point_l high for 1 cycle, state 3. Next move_tick -> (32,32), speed 8, state 1. Hit and exit in the same tick -> bounce, no point.
- reset asserted during PLAY -> all reset values next cycle. serve during PLAY -> ignored, state stays 2.
